// File: rtl/sprite_blitter.sv
// Sprite-draw engine: reads header + RGB565 pixels from ROM and streams scaled, keyed, clipped pixels to the LCD.
// Optional horizontal mirroring (flipX port) is built when SPRITE_FLIP_EN is defined.
module sprite_blitter #(
    parameter int          SCALE       = 2,
    parameter int          SCREEN_W    = 240,
    parameter int          SCREEN_H    = 320,
    parameter int          Y_OFFSET    = 100,
    parameter logic [15:0] TRANSPARENT = 16'd1,
    parameter int          ROM_LAT     = 2,
    parameter int          ADDR_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [8:0]        xOrigin,
    input  logic [9:0]        yOrigin,
    input  logic [ADDR_W-1:0] spriteBase,
    input  logic              draw,
    output logic              ready,
    output logic              done,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [15:0]       romData,
    output logic [7:0]        xAddr,
    output logic [8:0]        yAddr,
    output logic [15:0]       pixelData,
    output logic              pixelWrite,
`ifdef SPRITE_FLIP_EN
    input  logic              flipX,
`endif
    input  logic              pixelReady,
    output logic [2:0]        dbg_state_o
);
    typedef enum logic [2:0] {
        IDLE, READY, HDR_W, HDR_H, FETCH, BLOCK, WRITE, DONE
    } state_t;

    localparam logic [2:0] LAT   = 3'(ROM_LAT);
    localparam logic [1:0] S_M1  = 2'(SCALE - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [8:0]        w_q, w_d, h_q, h_d, c_q, c_d, r_q, r_d;
    logic [1:0]        sx_q, sx_d, sy_q, sy_d;
    logic [15:0]       word_q, word_d;
    logic [8:0]        xo_q, xo_d;
    logic [9:0]        yo_q, yo_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        xaddr_q, xaddr_d;
    logic [8:0]        yaddr_q, yaddr_d;
    logic [15:0]       pix_q, pix_d;
    logic              pw_q, pw_d, ready_q, ready_d, done_q, done_d;
    logic              advance, visible;
    logic [8:0]        col;
    logic [11:0]       x_pos, y_pos;

`ifdef SPRITE_FLIP_EN
    logic flip_q, flip_d;
    assign col = flip_q ? (w_q - 9'd1 - c_q) : c_q;
`else
    assign col = c_q;
`endif

    // Positions are widened so an origin near the screen edge clips instead of wrapping.
    assign x_pos   = 12'(xo_q) + 12'(col) * 12'(SCALE) + 12'(sx_q);
    assign y_pos   = 12'(yo_q) + 12'(r_q) * 12'(SCALE) + 12'(sy_q);
    assign visible = (word_q != TRANSPARENT) && (x_pos < 12'(SCREEN_W)) &&
                     (y_pos >= 12'(Y_OFFSET)) && (y_pos < 12'(Y_OFFSET + SCREEN_H));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        h_d        = h_q;
        c_d        = c_q;
        r_d        = r_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        word_d     = word_q;
        xo_d       = xo_q;
        yo_d       = yo_q;
        rom_addr_d = rom_addr_q;
        xaddr_d    = xaddr_q;
        yaddr_d    = yaddr_q;
        pix_d      = pix_q;
        advance    = 1'b0;
`ifdef SPRITE_FLIP_EN
        flip_d     = flip_q;
`endif
        case (state_q)
            IDLE:  if (!draw) state_d = READY;
            READY: if (draw) begin
                xo_d       = xOrigin;
                yo_d       = yOrigin;
                rom_addr_d = spriteBase;
`ifdef SPRITE_FLIP_EN
                flip_d     = flipX;
`endif
                cnt_d      = '0;
                state_d    = HDR_W;
            end
            HDR_W: if (cnt_q == LAT) begin
                w_d        = romData[8:0];
                rom_addr_d = rom_addr_q + 1'b1;
                cnt_d      = '0;
                state_d    = HDR_H;
            end else cnt_d = cnt_q + 3'd1;
            HDR_H: if (cnt_q == LAT) begin
                h_d        = romData[8:0];
                rom_addr_d = rom_addr_q + 1'b1;
                cnt_d      = '0;
                c_d        = '0;
                r_d        = '0;
                state_d    = (w_q == 9'd0 || romData[8:0] == 9'd0) ? DONE : FETCH;
            end else cnt_d = cnt_q + 3'd1;
            FETCH: if (cnt_q == LAT) begin
                word_d  = romData;
                sx_d    = '0;
                sy_d    = '0;
                state_d = BLOCK;
            end else cnt_d = cnt_q + 3'd1;
            BLOCK: if (visible) begin
                xaddr_d = x_pos[7:0];
                yaddr_d = 9'(y_pos - 12'(Y_OFFSET));
                pix_d   = word_q;
                state_d = WRITE;
            end else advance = 1'b1;
            WRITE: if (pixelReady) advance = 1'b1;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Step sx, then sy, then the source column/row; a new source pixel needs a ROM fetch.
        if (advance) begin
            state_d = BLOCK;
            if (sx_q != S_M1) sx_d = sx_q + 2'd1;
            else begin
                sx_d = '0;
                if (sy_q != S_M1) sy_d = sy_q + 2'd1;
                else begin
                    sy_d = '0;
                    if (c_q == w_q - 9'd1) begin
                        c_d = '0;
                        if (r_q == h_q - 9'd1) state_d = DONE;
                        else begin
                            r_d        = r_q + 9'd1;
                            rom_addr_d = rom_addr_q + 1'b1;
                            cnt_d      = '0;
                            state_d    = FETCH;
                        end
                    end else begin
                        c_d        = c_q + 9'd1;
                        rom_addr_d = rom_addr_q + 1'b1;
                        cnt_d      = '0;
                        state_d    = FETCH;
                    end
                end
            end
        end

        ready_d = (state_d == IDLE) || (state_d == READY);
        done_d  = (state_d == DONE);
        pw_d    = (state_d == WRITE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            w_q        <= '0;
            h_q        <= '0;
            c_q        <= '0;
            r_q        <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            word_q     <= '0;
            xo_q       <= '0;
            yo_q       <= '0;
            rom_addr_q <= '0;
            xaddr_q    <= '0;
            yaddr_q    <= '0;
            pix_q      <= '0;
            pw_q       <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPRITE_FLIP_EN
            flip_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            h_q        <= h_d;
            c_q        <= c_d;
            r_q        <= r_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            word_q     <= word_d;
            xo_q       <= xo_d;
            yo_q       <= yo_d;
            rom_addr_q <= rom_addr_d;
            xaddr_q    <= xaddr_d;
            yaddr_q    <= yaddr_d;
            pix_q      <= pix_d;
            pw_q       <= pw_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
`ifdef SPRITE_FLIP_EN
            flip_q     <= flip_d;
`endif
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign romAddr     = rom_addr_q;
    assign xAddr       = xaddr_q;
    assign yAddr       = yaddr_q;
    assign pixelData   = pix_q;
    assign pixelWrite  = pw_q;
    assign dbg_state_o = state_q;
endmodule
